i2c_bus_scheduler: RTL

//  Grants exclusive use of the shared I2C bus to one of N_CTRL on-chip I2C controllers.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_line_monitor.sv | 40 ++++
 rtl/i2c_bus_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and default timing for the I2C bus scheduler and its line monitor.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_ACTIVE,
        S_EXT_BUSY,
        S_BUF
    } sched_state_t;

    localparam int DEF_N_CTRL       = 3;
    localparam int DEF_T_BUF_CYC    = 50;
    localparam int DEF_START_TO_CYC = 1000;
    localparam int DEF_STUCK_TO_CYC = 10000;

endpackage

// File: rtl/i2c_line_monitor.sv
// Synchronises the resolved SDA/SCL lines and flags START/STOP conditions.
// Detection pulses appear 3 clk after the pin edge; reusable by the I2C peripheral.
module i2c_line_monitor (
    input  logic clk,
    input  logic rst,
    input  logic sda,
    input  logic scl,
    output logic start_det,
    output logic stop_det,
    output logic scl_level
);

    logic [1:0] sda_sync;
    logic [1:0] scl_sync;
    logic       sda_hist;
    logic       scl_hist;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle I2C lines are high, so presetting to 1 avoids a false edge out of reset.
            sda_sync  <= 2'b11;
            scl_sync  <= 2'b11;
            sda_hist  <= 1'b1;
            scl_hist  <= 1'b1;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            sda_sync  <= {sda_sync[0], sda};
            scl_sync  <= {scl_sync[0], scl};
            sda_hist  <= sda_sync[1];
            scl_hist  <= scl_sync[1];
            start_det <= sda_hist & ~sda_sync[1] & scl_hist & scl_sync[1];
            stop_det  <= ~sda_hist & sda_sync[1] & scl_hist & scl_sync[1];
        end
    end

    assign scl_level = scl_sync[1];

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Round-robin owner selection for a shared I2C bus with bus-free time,
// start timeout and stuck-SCL recovery.
module i2c_bus_scheduler
    import i2c_pkg::*;
#(
    parameter int N_CTRL       = DEF_N_CTRL,
    parameter int T_BUF_CYC    = DEF_T_BUF_CYC,
    parameter int START_TO_CYC = DEF_START_TO_CYC,
    parameter int STUCK_TO_CYC = DEF_STUCK_TO_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      SDA,
    input  logic                      SCL,
    input  logic [N_CTRL-1:0]         req,
    input  logic                      err_clr,
    output logic [N_CTRL-1:0]         gnt,
    output logic [$clog2(N_CTRL)-1:0] owner_id,
    output logic                      owner_vld,
    output logic                      bus_busy,
    output logic                      timeout_err,
    output logic                      stuck_err
);

    localparam int ID_W    = $clog2(N_CTRL);
    localparam int START_W = $clog2(START_TO_CYC + 1);
    localparam int STUCK_W = $clog2(STUCK_TO_CYC + 1);
    localparam int BUF_W   = $clog2(T_BUF_CYC + 1);

    localparam logic [START_W-1:0] START_MAX = START_W'(START_TO_CYC);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_TO_CYC);
    localparam logic [BUF_W-1:0]   BUF_LAST  = BUF_W'(T_BUF_CYC - 1);
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(N_CTRL - 1);

    logic start_det, stop_det, scl_level;

    i2c_line_monitor u_line_monitor (
        .clk       (clk),
        .rst       (rst),
        .sda       (SDA),
        .scl       (SCL),
        .start_det (start_det),
        .stop_det  (stop_det),
        .scl_level (scl_level)
    );

    sched_state_t       state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic               stuck_q, stuck_d, stuck_set;
    logic [START_W-1:0] start_cnt_q, start_cnt_d;
    logic [STUCK_W-1:0] stuck_cnt_q, stuck_cnt_d;
    logic [BUF_W-1:0]   buf_cnt_q, buf_cnt_d;

    logic               pick_vld;
    logic [ID_W-1:0]    pick_idx;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    next_ptr;
    int                 idx;

    // Scan downwards so the requester closest to rr_ptr is the last one written.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        cand     = '0;
        for (int i = N_CTRL - 1; i >= 0; i--) begin
            idx  = (int'(rr_ptr_q) + i) % N_CTRL;
            cand = ID_W'(idx);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign next_ptr = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        vld_d       = vld_q;
        timeout_d   = 1'b0;
        stuck_set   = 1'b0;
        start_cnt_d = '0;
        stuck_cnt_d = '0;
        buf_cnt_d   = '0;
        busy_d      = busy_q;

        if (start_det)     busy_d = 1'b1;
        else if (stop_det) busy_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    state_d = S_EXT_BUSY;
                end else if (pick_vld) begin
                    owner_d = pick_idx;
                    vld_d   = 1'b1;
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (start_det) begin
                    state_d = S_ACTIVE;
                end else if (!req[owner_q] || start_cnt_q == START_MAX) begin
                    timeout_d = req[owner_q];
                    vld_d     = 1'b0;
                    rr_ptr_d  = next_ptr;
                    state_d   = S_IDLE;
                end else begin
                    start_cnt_d = start_cnt_q + START_W'(1);
                end
            end
            S_ACTIVE: begin
                if (stop_det) begin
                    vld_d    = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = S_BUF;
                end else if (stuck_cnt_q == STUCK_MAX) begin
                    stuck_set = 1'b1;
                    vld_d     = 1'b0;
                    state_d   = S_EXT_BUSY;
                end else if (!scl_level) begin
                    stuck_cnt_d = stuck_cnt_q + STUCK_W'(1);
                end
            end
            S_EXT_BUSY: begin
                if (stop_det) state_d = S_BUF;
            end
            S_BUF: begin
                if (start_det)                  state_d = S_EXT_BUSY;
                else if (buf_cnt_q == BUF_LAST) state_d = S_IDLE;
                else                            buf_cnt_d = buf_cnt_q + BUF_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        stuck_d = stuck_set ? 1'b1 : (err_clr ? 1'b0 : stuck_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stuck_q     <= 1'b0;
            start_cnt_q <= '0;
            stuck_cnt_q <= '0;
            buf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            vld_q       <= vld_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            stuck_q     <= stuck_d;
            start_cnt_q <= start_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
            buf_cnt_q   <= buf_cnt_d;
        end
    end

    assign gnt         = vld_q ? (N_CTRL'(1) << owner_q) : '0;
    assign owner_id    = owner_q;
    assign owner_vld   = vld_q;
    assign bus_busy    = busy_q;
    assign timeout_err = timeout_q;
    assign stuck_err   = stuck_q;

endmodule
